// File: rtl/bitwise_logic_pipe.sv
// N-bit two-operand logic unit (8 gate functions) with valid/ready handshakes,
// a two-entry skid buffer, result reduction flags and a saturating transfer counter.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             r_or_vld;
  logic [WIDTH-1:0] r_or_dat;
  logic             r_sk_vld;
  logic [WIDTH-1:0] r_sk_dat;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_res;
  logic             w_in_fire;
  logic             w_out_fire;

  always_comb begin
    w_res = '0;
    case (op)
      3'd0:    w_res = a & b;
      3'd1:    w_res = a | b;
      3'd2:    w_res = ~a;
      3'd3:    w_res = ~(a & b);
      3'd4:    w_res = ~(a | b);
      3'd5:    w_res = a ^ b;
      3'd6:    w_res = ~(a ^ b);
      default: w_res = a;
    endcase
  end

  // Skid slot occupancy alone gates acceptance, so in_ready never depends on out_ready.
  assign in_ready   = !r_sk_vld && !rst;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_or_vld && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_or_vld <= 1'b0;
      r_or_dat <= '0;
      r_sk_vld <= 1'b0;
      r_sk_dat <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_out_fire) begin
        if (r_sk_vld) begin
          r_or_dat <= r_sk_dat;
          r_sk_vld <= 1'b0;
        end else if (w_in_fire) begin
          r_or_dat <= w_res;
        end else begin
          r_or_vld <= 1'b0;
        end
      end else if (w_in_fire) begin
        if (!r_or_vld) begin
          r_or_vld <= 1'b1;
          r_or_dat <= w_res;
        end else begin
          r_sk_vld <= 1'b1;
          r_sk_dat <= w_res;
        end
      end
      if (w_out_fire && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_or_vld;
  assign out       = r_or_dat;
  assign red_and   = &r_or_dat;
  assign red_or    = |r_or_dat;
  assign red_xor   = ^r_or_dat;
  assign xfer_cnt  = r_cnt;

endmodule
